// File: rtl/cdim_fetch_pkg.sv
// Shared fetch-path definitions.
//   INST_W / PC_W  : instruction and program-counter widths
//   fetch_entry_t  : one queued instruction together with its PC
//   pc_of_slot     : PC of slot i in a fetch packet starting at base
//   ptr_add        : circular-buffer index arithmetic, (ptr + off) mod depth
package cdim_fetch_pkg;

  localparam int INST_W = 32;
  localparam int PC_W   = 32;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Instructions are 4 bytes; the PC wraps naturally at 32 bits.
  function automatic logic [PC_W-1:0] pc_of_slot(input logic [PC_W-1:0] base,
                                                 input int unsigned     slot);
    return base + (PC_W'(slot) << 2);
  endfunction

  function automatic int unsigned ptr_add(input int unsigned ptr,
                                          input int unsigned off,
                                          input int unsigned depth);
    return (ptr + off) % depth;
  endfunction

endpackage

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue.
// Buffers packets of up to FETCH_W instructions in a DEPTH-entry circular
// queue and presents the ISSUE_W oldest entries to decode.
// Ports:
//   clk, resetn       clock, asynchronous active-low reset
//   flush             discard all contents (wins over push and pop)
//   in_valid/in_ready fetch handshake; in_ready means FETCH_W entries free
//   in_cnt            valid slots in the packet, counted from slot 0
//   in_pc, in_inst    PC of slot 0, packed slot instructions
//   out_valid         thermometer-coded lane valids
//   out_inst, out_pc  head entries, lanes zeroed when invalid
//   out_pop           lanes consumed this cycle
//   count             current occupancy, 0..DEPTH
module inst_queue
  import cdim_fetch_pkg::*;
#(
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2,
  parameter int DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [$clog2(FETCH_W+1)-1:0]  in_cnt,
  input  logic [PC_W-1:0]               in_pc,
  input  logic [INST_W*FETCH_W-1:0]     in_inst,
  output logic [ISSUE_W-1:0]            out_valid,
  output logic [INST_W*ISSUE_W-1:0]     out_inst,
  output logic [PC_W*ISSUE_W-1:0]       out_pc,
  input  logic [$clog2(ISSUE_W+1)-1:0]  out_pop,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int IN_W  = $clog2(FETCH_W+1);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;

  logic [CNT_W-1:0] free_n;
  logic [IN_W-1:0]  in_cnt_c;
  logic             push_ok;
  logic [CNT_W-1:0] push_n;
  logic [CNT_W-1:0] pop_lim;
  logic [CNT_W-1:0] pop_req;
  logic [CNT_W-1:0] pop_n;

  // in_ready depends on registered occupancy only, so a same-cycle pop
  // never opens a combinational path into the fetch handshake.
  assign free_n   = CNT_W'(DEPTH) - count_q;
  assign in_ready = (free_n >= CNT_W'(FETCH_W));
  assign push_ok  = in_valid & in_ready & ~flush;

  assign in_cnt_c = (in_cnt > IN_W'(FETCH_W)) ? IN_W'(FETCH_W) : in_cnt;
  assign push_n   = push_ok ? CNT_W'(in_cnt_c) : '0;

  // Pops are clamped so an illegal request can never underflow the queue.
  assign pop_lim  = (count_q < CNT_W'(ISSUE_W)) ? count_q : CNT_W'(ISSUE_W);
  assign pop_req  = CNT_W'(out_pop);
  assign pop_n    = flush ? '0 : ((pop_req > pop_lim) ? pop_lim : pop_req);

  assign count    = count_q;

  // Control state: pointers and occupancy
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= PTR_W'(ptr_add(32'(head_q), 32'(pop_n), DEPTH));
      tail_q  <= PTR_W'(ptr_add(32'(tail_q), 32'(push_n), DEPTH));
      count_q <= count_q + push_n - pop_n;
    end
  end

  // Storage write: slot i lands at tail+i, wrapping past DEPTH-1 to 0
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_W; i++) begin
      if (CNT_W'(i) < push_n) begin
        mem[PTR_W'(ptr_add(32'(tail_q), i, DEPTH))].pc   <= pc_of_slot(in_pc, i);
        mem[PTR_W'(ptr_add(32'(tail_q), i, DEPTH))].inst <= in_inst[INST_W*i +: INST_W];
      end
    end
  end

  // Read lanes: combinational from registered head; invalid lanes read zero
  always_comb begin
    out_valid = '0;
    out_inst  = '0;
    out_pc    = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      if (count_q > CNT_W'(i)) begin
        out_valid[i]                 = 1'b1;
        out_inst[INST_W*i +: INST_W] = mem[PTR_W'(ptr_add(32'(head_q), i, DEPTH))].inst;
        out_pc[PC_W*i +: PC_W]       = mem[PTR_W'(ptr_add(32'(head_q), i, DEPTH))].pc;
      end
    end
  end

  // Decode may only consume lanes that are actually presented.
  pop_within_limit: assert property (
    @(posedge clk) disable iff (!resetn) (flush || (pop_req <= pop_lim))
  );

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue (FETCH_W=2, ISSUE_W=2, DEPTH=16).
// A queue of {pc, inst} records is the reference: pushes append in_cnt
// records with consecutive PCs when at least FETCH_W entries are free,
// pops remove from the front, flush empties it.
module tb_inst_queue;

  localparam int FETCH_W = 2;
  localparam int ISSUE_W = 2;
  localparam int DEPTH   = 16;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_cnt;
  logic [31:0] in_pc;
  logic [63:0] in_inst;
  logic [1:0]  out_valid;
  logic [63:0] out_inst;
  logic [63:0] out_pc;
  logic [1:0]  out_pop;
  logic [4:0]  count;

  inst_queue #(.FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_cnt(in_cnt),
    .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
    .out_pop(out_pop), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int legal_pop(input int want);
    int m;
    m = q.size();
    if (m > ISSUE_W) m = ISSUE_W;
    return (want < m) ? want : m;
  endfunction

  task automatic check_model();
    logic [1:0]  ev;
    logic [63:0] ei;
    logic [63:0] ep;
    ev = '0;
    ei = '0;
    ep = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      if (i < q.size()) begin
        ev[i]          = 1'b1;
        ei[32*i +: 32] = q[i].inst;
        ep[32*i +: 32] = q[i].pc;
      end
    end
    chk("count",     64'(count),     64'(q.size()));
    chk("in_ready",  64'(in_ready),  64'((DEPTH - q.size()) >= FETCH_W));
    chk("out_valid", 64'(out_valid), 64'(ev));
    chk("out_inst",  out_inst,       ei);
    chk("out_pc",    out_pc,         ep);
  endtask

  // One clock: drive at negedge, compare against the model, then advance
  // the model across the rising edge.
  task automatic cycle(input logic v, input int cnt, input logic [31:0] pc,
                       input logic [31:0] i0, input logic [31:0] i1,
                       input int pop, input logic fl, output logic acc);
    @(negedge clk);
    in_valid = v;
    in_cnt   = 2'(cnt);
    in_pc    = pc;
    in_inst  = {i1, i0};
    out_pop  = 2'(pop);
    flush    = fl;
    #1;
    check_model();
    acc = v && !fl && ((DEPTH - q.size()) >= FETCH_W);
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      for (int k = 0; k < pop; k++) void'(q.pop_front());
      if (acc) begin
        for (int s = 0; s < cnt; s++) q.push_back('{pc + 32'(4*s), (s == 0) ? i0 : i1});
      end
    end
  endtask

  task automatic peek();
    @(negedge clk);
    in_valid = 1'b0;
    in_cnt   = '0;
    out_pop  = '0;
    flush    = 1'b0;
    #1;
    check_model();
  endtask

  logic        acc;
  logic [31:0] pc;
  int          pushed;
  int          guard;

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    resetn   = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_cnt   = '0;
    in_pc    = '0;
    in_inst  = '0;
    out_pop  = '0;
    #1 resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_count",     64'(count),     64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_inst",  out_inst,       64'd0);
    chk("rst_out_pc",    out_pc,         64'd0);
    resetn = 1'b1;
    peek();

    // Basic order
    cycle(1'b1, 2, 32'hBFC0_0000, 32'h1111_1111, 32'h2222_2222, 0, 1'b0, acc);
    peek();
    chk("basic_valid", 64'(out_valid), 64'h3);
    chk("basic_pc",    out_pc,         64'hBFC0_0004_BFC0_0000);
    chk("basic_inst",  out_inst,       64'h2222_2222_1111_1111);
    cycle(1'b0, 0, 0, 0, 0, legal_pop(2), 1'b0, acc);

    // Unaligned single slot
    cycle(1'b1, 1, 32'hBFC0_0004, 32'h3333_3333, 32'h4444_4444, 0, 1'b0, acc);
    peek();
    chk("single_valid", 64'(out_valid), 64'h1);
    chk("single_pc",    out_pc,         64'h0000_0000_BFC0_0004);
    chk("single_count", 64'(count),     64'd1);
    cycle(1'b0, 0, 0, 0, 0, 0, 1'b1, acc);

    // Fill to DEPTH, then backpressure
    for (int k = 0; k < 8; k++)
      cycle(1'b1, 2, 32'h1000 + 32'(8*k), $urandom, $urandom, 0, 1'b0, acc);
    peek();
    chk("full_count", 64'(count),    64'd16);
    chk("full_ready", 64'(in_ready), 64'd0);
    cycle(1'b1, 2, 32'hDEAD_0000, 32'hDEAD_DEAD, 32'hBEEF_BEEF, 0, 1'b0, acc);
    peek();
    chk("drop_count", 64'(count),     64'd16);
    chk("drop_pc0",   64'(out_pc[31:0]), 64'h1000);
    cycle(1'b0, 0, 0, 0, 0, legal_pop(2), 1'b0, acc);
    peek();
    chk("unfull_ready", 64'(in_ready), 64'd1);
    chk("unfull_count", 64'(count),    64'd14);
    cycle(1'b0, 0, 0, 0, 0, 0, 1'b1, acc);

    // Advance head to 14, then push 2 / pop 1 across the wrap
    pc = 32'h2000;
    pushed = 0;
    guard = 0;
    while ((pushed < 14 || q.size() > 0) && guard < 50) begin
      cycle(pushed < 14, 2, pc, $urandom, $urandom, legal_pop(2), 1'b0, acc);
      if (acc) begin
        pc += 8;
        pushed += 2;
      end
      guard++;
    end
    chk("advance_done", 64'(q.size()), 64'd0);
    for (int k = 0; k < 20; k++) begin
      cycle(1'b1, 2, pc, $urandom, $urandom, legal_pop(1), 1'b0, acc);
      if (acc) pc += 8;
    end
    peek();
    cycle(1'b0, 0, 0, 0, 0, 0, 1'b1, acc);

    // Flush beats simultaneous push and pop
    for (int k = 0; k < 3; k++)
      cycle(1'b1, 2, 32'h3000 + 32'(8*k), $urandom, $urandom, 0, 1'b0, acc);
    peek();
    chk("pre_flush_count", 64'(count), 64'd6);
    cycle(1'b1, 2, 32'h4000, $urandom, $urandom, 2, 1'b1, acc);
    peek();
    chk("flush_count", 64'(count),     64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    cycle(1'b1, 1, 32'h8000_0000, 32'hCAFE_F00D, 32'h0, 0, 1'b0, acc);
    peek();
    chk("post_flush_pc",    64'(out_pc[31:0]),   64'h8000_0000);
    chk("post_flush_inst",  64'(out_inst[31:0]), 64'hCAFE_F00D);
    chk("post_flush_valid", 64'(out_valid),      64'h1);

    // Random traffic; fetch holds a refused packet until it is taken
    begin
      logic        v;
      logic        fl;
      int          cnt;
      logic [31:0] i0;
      logic [31:0] i1;
      pc  = 32'hFFFF_FFE0;
      cnt = $urandom_range(0, 2);
      i0  = $urandom;
      i1  = $urandom;
      for (int n = 0; n < 400; n++) begin
        v  = ($urandom % 4) != 0;
        fl = ($urandom % 25) == 0;
        cycle(v, cnt, pc, i0, i1, legal_pop($urandom_range(0, 2)), fl, acc);
        if (acc || fl) begin
          if (acc) pc += 32'(4*cnt);
          cnt = $urandom_range(0, 2);
          i0  = $urandom;
          i1  = $urandom;
        end
      end
    end
    peek();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Parametrised fetch-to-decode instruction queue. Successor to the fixed two-slot fetch splitter.
- Accepts packets of up to FETCH_W instructions from the instruction SRAM path and buffers them in a circular queue.
- Presents up to ISSUE_W oldest instructions, with their PCs, to the multi-issue decode stage.
- Decouples fetch from decode stalls. Supports pipeline flush on branch or exception redirect.

Parameters:
- FETCH_W, 2, instructions delivered per fetch beat (1..4).
- ISSUE_W, 2, instructions presented per cycle to decode (1..4).
- DEPTH, 16, queue entries; power of two; must be >= 2*FETCH_W.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- resetn  in  1  asynchronous active-low reset.
- flush  in  1  discard all contents; highest priority.
- in_valid  in  1  fetch packet present this cycle.
- in_ready  out  1  queue can take a full packet: free entries >= FETCH_W.
- in_cnt  in  clog2(FETCH_W+1)  number of valid slots, counted from slot 0 (0..FETCH_W).
- in_pc  in  32  PC of slot 0.
- in_inst  in  32*FETCH_W  slot i in bits [32i+31:32i].
- out_valid  out  ISSUE_W  lane i valid iff count > i (thermometer code).
- out_inst  out  32*ISSUE_W  lane i = entry head+i.
- out_pc  out  32*ISSUE_W  PC of lane i.
- out_pop  in  clog2(ISSUE_W+1)  lanes consumed this cycle (0..ISSUE_W).
- count  out  clog2(DEPTH+1)  current occupancy.

Behaviour:
- Storage: DEPTH entries of {pc[31:0], inst[31:0]}. Head pointer, tail pointer and count; pointers wrap modulo DEPTH.
- Reset (resetn=0, asynchronous):
  - head=tail=count=0.
  - out_valid=0; out_inst=0 and out_pc=0 (lanes masked to zero when invalid).
  - in_ready=1.
  - Entry contents are don't-care.
- Push condition: in_valid & in_ready & ~flush.
  - Writes in_cnt entries at tail..tail+in_cnt-1 (mod DEPTH).
  - Entry i gets inst slot i and pc = in_pc + 4*i (32-bit wrap).
  - tail += in_cnt.
  - in_cnt=0 with in_valid=1 is legal and is a no-op.
- Push while in_ready=0: dropped. No partial write. Fetch must hold the packet and retry.
- Pop: out_pop=k removes k head entries; head += k.
  - Requires k <= min(count, ISSUE_W). Violation is a protocol error, covered by an assertion.
  - The queue clamps k to min(count, ISSUE_W) and never underflows.
- Simultaneous push and pop in one cycle: count_next = count + pushed - popped.
  - in_ready is computed from registered count only; no pop-to-push combinational path.
- Flush:
  - Next cycle head=tail=count=0, out_valid=0.
  - A push or pop in the same cycle is ignored.
  - Flush during reset has no effect.
- Read latency:
  - Outputs are combinational from registered state (head entries).
  - A pushed instruction is visible on out lanes in the cycle after the push edge. No write-to-read bypass.
- Ordering: strict FIFO; lane 0 is always the oldest instruction.
- Full boundary: count=DEPTH gives in_ready=0. With FETCH_W=2 and count=DEPTH-1, in_ready=0 even if in_cnt would be 1.
- Empty boundary: count=0 gives out_valid=0.
- Wrap-around: a write spanning index DEPTH-1 to 0 splits across the boundary transparently. PCs stay consecutive.
- count is exact at all times, 0..DEPTH.

Decomposition:
- Shared package cdim_fetch_pkg holds:
  - INST_W=32 and PC_W=32.
  - The fetch-entry struct {pc, inst}.
  - Function pc_of_slot(base, i).
- Lane-index modulo arithmetic lives in the package as a function (ptr_add).
- No sub-module: the storage array, pointers and output muxes belong in one module.

Test Plan:
- Reset then idle: resetn low for 3 cycles, then high -> count=0, out_valid=2'b00, in_ready=1.
- Basic order: push in_pc=0xBFC00000, in_cnt=2, inst {0x11111111, 0x22222222}; pop 0 -> next cycle out_valid=2'b11, lane0 pc 0xBFC00000 inst 0x11111111, lane1 pc 0xBFC00004 inst 0x22222222.
- Unaligned single slot: push in_pc=0xBFC00004, in_cnt=1 -> out_valid=2'b01, lane0 pc 0xBFC00004, count=1.
- Fill and backpressure:
  - Push 8 full packets with no pops (DEPTH=16) -> count=16, in_ready=0.
  - 9th packet not written.
  - Pop 2 -> in_ready=1 the next cycle.
- Wrap plus concurrency: advance head to 14, then push 2 while popping 1 each cycle for 20 cycles -> PCs strictly increasing by 4 across index 15->0; count tracks +1 per cycle until in_ready=0.
- Flush priority: count=6, assert flush together with push in_cnt=2 and pop 2 -> next cycle count=0, out_valid=0; the following push of in_pc 0x80000000 appears on lane0.
